rggen_axi4lite_slave_bridge: RTL

//  AXI4-Lite slave front end for a rggen register block. Accepts AXI4-Lite

---
 rtl/rggen_axi4lite_slave_bridge_if.sv | 62 ++++++
 rtl/rggen_axi4lite_slave_bridge.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rggen_axi4lite_slave_bridge_if.sv
// AXI4-Lite channel bundle and rggen register-bus bundle used by the slave bridge.
// Both are parameterised by address and data width and carry no logic.
interface rggen_axi4lite_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     awvalid;
  logic                     awready;
  logic [ADDRESS_WIDTH-1:0] awaddr;
  logic [2:0]               awprot;
  logic                     wvalid;
  logic                     wready;
  logic [BUS_WIDTH-1:0]     wdata;
  logic [BUS_WIDTH/8-1:0]   wstrb;
  logic                     bvalid;
  logic                     bready;
  logic [1:0]               bresp;
  logic                     arvalid;
  logic                     arready;
  logic [ADDRESS_WIDTH-1:0] araddr;
  logic [2:0]               arprot;
  logic                     rvalid;
  logic                     rready;
  logic [BUS_WIDTH-1:0]     rdata;
  logic [1:0]               rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

interface rggen_bus_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     valid;
  logic                     write;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   strobe;
  logic                     ready;
  logic [1:0]               status;
  logic [BUS_WIDTH-1:0]     read_data;

  modport master (
    output valid, write, address, write_data, strobe,
    input  ready, status, read_data
  );

  modport slave (
    input  valid, write, address, write_data, strobe,
    output ready, status, read_data
  );
endinterface

// File: rtl/rggen_axi4lite_slave_bridge.sv
// AXI4-Lite slave to rggen bus bridge: AW/W/AR held per channel, one bus access at a time.
// Bus valid the cycle after the last request handshake; B/R held until bready/rready.
module rggen_axi4lite_slave_bridge #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32,
  parameter bit WRITE_FIRST   = 1'b1
) (
  input logic         i_clk,
  input logic         i_rst_n,
  rggen_axi4lite_if.slave axi4lite_if,
  rggen_bus_if.master     bus_if
);
  localparam int STRB_WIDTH = BUS_WIDTH / 8;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] BUS_ACCESS = 2'd1;
  localparam logic [1:0] RESPONSE   = 2'd2;

  logic [1:0]               state_q,   state_d;
  logic                     prio_q,    prio_d;
  logic                     write_q,   write_d;
  logic                     aw_hold_q, aw_hold_d;
  logic                     w_hold_q,  w_hold_d;
  logic                     ar_hold_q, ar_hold_d;
  logic [ADDRESS_WIDTH-1:0] awaddr_q,  awaddr_d;
  logic [ADDRESS_WIDTH-1:0] araddr_q,  araddr_d;
  logic [BUS_WIDTH-1:0]     wdata_q,   wdata_d;
  logic [STRB_WIDTH-1:0]    wstrb_q,   wstrb_d;
  logic [1:0]               status_q,  status_d;
  logic [BUS_WIDTH-1:0]     rdata_q,   rdata_d;

  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  logic write_elig, read_elig;
  logic bus_valid;
  logic unused_prot;

  assign unused_prot = ^{axi4lite_if.awprot, axi4lite_if.arprot};

  assign aw_hs = axi4lite_if.awvalid && !aw_hold_q;
  assign w_hs  = axi4lite_if.wvalid  && !w_hold_q;
  assign ar_hs = axi4lite_if.arvalid && !ar_hold_q;
  assign b_hs  = (state_q == RESPONSE) &&  write_q && axi4lite_if.bready;
  assign r_hs  = (state_q == RESPONSE) && !write_q && axi4lite_if.rready;

  // Same-cycle handshakes count as held so the access starts the very next cycle.
  assign write_elig = (aw_hold_q || aw_hs) && (w_hold_q || w_hs);
  assign read_elig  = ar_hold_q || ar_hs;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    write_d   = write_q;
    aw_hold_d = aw_hold_q;
    w_hold_d  = w_hold_q;
    ar_hold_d = ar_hold_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    status_d  = status_q;
    rdata_d   = rdata_q;

    if (aw_hs) begin
      aw_hold_d = 1'b1;
      awaddr_d  = axi4lite_if.awaddr;
    end
    if (w_hs) begin
      w_hold_d = 1'b1;
      wdata_d  = axi4lite_if.wdata;
      wstrb_d  = axi4lite_if.wstrb;
    end
    if (ar_hs) begin
      ar_hold_d = 1'b1;
      araddr_d  = axi4lite_if.araddr;
    end

    case (state_q)
      IDLE: begin
        if (write_elig || read_elig) begin
          state_d = BUS_ACCESS;
          write_d = write_elig && (!read_elig || prio_q);
          if (write_elig && read_elig) begin
            prio_d = !prio_q;
          end
        end
      end
      BUS_ACCESS: begin
        if (bus_if.ready) begin
          status_d = bus_if.status;
          rdata_d  = bus_if.read_data;
          state_d  = RESPONSE;
        end
      end
      RESPONSE: begin
        if (b_hs) begin
          aw_hold_d = 1'b0;
          w_hold_d  = 1'b0;
          state_d   = IDLE;
        end
        if (r_hs) begin
          ar_hold_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      prio_q    <= WRITE_FIRST;
      write_q   <= 1'b0;
      aw_hold_q <= 1'b0;
      w_hold_q  <= 1'b0;
      ar_hold_q <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      status_q  <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      write_q   <= write_d;
      aw_hold_q <= aw_hold_d;
      w_hold_q  <= w_hold_d;
      ar_hold_q <= ar_hold_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      status_q  <= status_d;
      rdata_q   <= rdata_d;
    end
  end

  assign axi4lite_if.awready = !aw_hold_q;
  assign axi4lite_if.wready  = !w_hold_q;
  assign axi4lite_if.arready = !ar_hold_q;
  assign axi4lite_if.bvalid  = (state_q == RESPONSE) &&  write_q;
  assign axi4lite_if.rvalid  = (state_q == RESPONSE) && !write_q;
  assign axi4lite_if.bresp   = status_q;
  assign axi4lite_if.rresp   = status_q;
  assign axi4lite_if.rdata   = rdata_q;

  // Bus outputs are forced to zero whenever no access is in progress.
  assign bus_valid         = (state_q == BUS_ACCESS);
  assign bus_if.valid      = bus_valid;
  assign bus_if.write      = bus_valid && write_q;
  assign bus_if.address    = !bus_valid ? '0 : (write_q ? awaddr_q : araddr_q);
  assign bus_if.write_data = (bus_valid && write_q) ? wdata_q : '0;
  assign bus_if.strobe     = (bus_valid && write_q) ? wstrb_q : '0;
endmodule
